// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result valid-ready bundle for pipe_adder.
// The sub signal exists only when PIPE_ADDER_SUB_EN is defined.
interface pipe_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub;
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
`else
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: SEG-bit-per-stage pipelined adder with valid/ready and a global stall.
// Optional subtract mode (a - b - !cin) when PIPE_ADDER_SUB_EN is defined.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic           clk,
    input logic           rst_n,
    pipe_adder_if.slave   bus
);
    localparam int STAGES = WIDTH / SEG;
    localparam int L      = STAGES - 1;
    if (WIDTH < 1 || SEG < 1 || WIDTH % SEG != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be >= 1 and a multiple of SEG");
    end
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [STAGES-1:0] v_q, c_q;
    logic [WIDTH-1:0] a_p [STAGES];
    logic [WIDTH-1:0] b_p [STAGES];
    logic [WIDTH-1:0] s_p [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [STAGES-1:0] v_p, c_p, c_d;
    logic [SEG:0]     t;
    logic [WIDTH-1:0] b_eff;
    logic             adv;
`ifdef PIPE_ADDER_SUB_EN
    assign b_eff = bus.sub ? ~bus.b : bus.b;
`else
    assign b_eff = bus.b;
`endif
    assign adv          = !v_q[L] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = v_q[L];
    assign bus.sum      = s_q[L];
    assign bus.cout     = c_q[L];
    assign bus.ovf      = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
    // Stage k sees the previous stage's registers (stage 0 sees the input beat) and fills segment k.
    always_comb begin
        t      = '0;
        a_p[0] = bus.a;
        b_p[0] = b_eff;
        s_p[0] = '0;
        c_p[0] = bus.cin;
        v_p[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_p[k] = a_q[k-1];
            b_p[k] = b_q[k-1];
            s_p[k] = s_q[k-1];
            c_p[k] = c_q[k-1];
            v_p[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, a_p[k][k*SEG +: SEG]} + {1'b0, b_p[k][k*SEG +: SEG]} + {{SEG{1'b0}}, c_p[k]};
            s_d[k] = s_p[k];
            s_d[k][k*SEG +: SEG] = t[SEG-1:0];
            c_d[k] = t[SEG];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q <= v_p;
            c_q <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_p[k];
                b_q[k] <= b_p[k];
                s_q[k] <= s_d[k];
            end
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed checks of pipe_adder (WIDTH=16, SEG=4) with immediate assertions.
module tb_pipe_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    pipe_adder_if #(.WIDTH(16)) bus ();
    pipe_adder #(.WIDTH(16), .SEG(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = ci;
`ifdef PIPE_ADDER_SUB_EN
        bus.sub = sb;
`else
        if (sb) $display("sub requested without PIPE_ADDER_SUB_EN");
`endif
    endtask
    task automatic one(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic sb, input logic [15:0] es, input logic ec, input logic eo);
        tick();
        beat(a, b, ci, sb);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk({tag, "_early"}, {31'd0, bus.out_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        one("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        one("mixed", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        // Beat m enters after edge m and is visible after edge m+4.
        for (int j = 0; j < 13; j++) begin
            tick();
            if (j < 8) begin
                logic [15:0] iv;
                iv = 16'(j);
                beat(iv, 16'(2 * j), iv[0], 1'b0);
            end else bus.in_valid = 1'b0;
            @(negedge clk);
            if (j >= 4 && j < 12) begin
                logic [15:0] m;
                m = 16'(j - 4);
                chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stream_sum", {16'd0, bus.sum}, {16'd0, 16'(3 * (j - 4)) + {15'd0, m[0]}});
                chk("stream_ready", {31'd0, bus.in_ready}, 32'd1);
            end else chk("stream_bubble", {31'd0, bus.out_valid}, 32'd0);
        end
        bus.out_ready = 1'b0;
        tick();
        beat(16'd100, 16'd23, 1'b0, 1'b0);
        tick();
        beat(16'h1000, 16'h0234, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        beat(16'h0001, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_sum", {16'd0, bus.sum}, 32'h007B);
            chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_y_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("drain_y_sum", {16'd0, bus.sum}, 32'h1234);
        tick();
        @(negedge clk);
        chk("drain_gap1", {31'd0, bus.out_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("drain_gap2", {31'd0, bus.out_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("drain_z_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("drain_z_sum", {16'd0, bus.sum}, 32'h0002);
        tick();
        @(negedge clk);
        chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            beat(16'(i + 1), 16'h0010, 1'b0, 1'b0);
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            chk("postrst_valid", {31'd0, bus.out_valid}, 32'd0);
        end
`ifdef PIPE_ADDER_SUB_EN
        one("sub_neg", 16'd5, 16'd7, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        one("sub_off", 16'd5, 16'd7, 1'b0, 1'b0, 16'd12, 1'b0, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
